alu_exec: RTL

Iterative execute-stage ALU: the consumer of the 4-bit `alu_ctrl` code produced by the ALU control decoder. It accepts one operation per valid/ready handshake, finishes logic/arithmetic/compare ops in one cycle, and runs shifts serially at one bit per cycle to avoid a barrel shifter. It presents a registered `result` and `zero` flag (branch compare) to writeback/branch logic through a second valid/ready handshake.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_core.sv | 29 ++
 rtl/alu_exec.sv | 129 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control decoder and the execute-stage ALU:
// operation codes, the execute FSM state type and a shift-op classifier.
package alu_pkg;

  // Raw 4-bit operation codes as produced by the ALU control decoder.
  localparam logic [3:0] ALU_CODE_ADD  = 4'b0000;
  localparam logic [3:0] ALU_CODE_SUB  = 4'b1000;
  localparam logic [3:0] ALU_CODE_SLL  = 4'b0001;
  localparam logic [3:0] ALU_CODE_SLT  = 4'b0010;
  localparam logic [3:0] ALU_CODE_SLTU = 4'b0011;
  localparam logic [3:0] ALU_CODE_XOR  = 4'b0100;
  localparam logic [3:0] ALU_CODE_SRL  = 4'b0101;
  localparam logic [3:0] ALU_CODE_OR   = 4'b0110;
  localparam logic [3:0] ALU_CODE_AND  = 4'b0111;
  localparam logic [3:0] ALU_CODE_SRA  = 4'b1101;

  typedef enum logic [3:0] {
    ALU_ADD  = ALU_CODE_ADD,
    ALU_SUB  = ALU_CODE_SUB,
    ALU_SLL  = ALU_CODE_SLL,
    ALU_SLT  = ALU_CODE_SLT,
    ALU_SLTU = ALU_CODE_SLTU,
    ALU_XOR  = ALU_CODE_XOR,
    ALU_SRL  = ALU_CODE_SRL,
    ALU_OR   = ALU_CODE_OR,
    ALU_AND  = ALU_CODE_AND,
    ALU_SRA  = ALU_CODE_SRA
  } alu_ctrl_e;

  // Execute FSM: accept, shift serially, hold result for downstream.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Shifts are the only multi-cycle operations.
  function automatic logic is_shift_op(input logic [3:0] code);
    return (code == ALU_CODE_SLL) || (code == ALU_CODE_SRL) || (code == ALU_CODE_SRA);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational ALU for the non-shift operations.
// Unknown codes (and the shift codes, which never reach this result) act as ADD.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  // Select the single-cycle result for the requested operation.
  always_comb begin
    // NOTE: y gets a default before the case so every path assigns it and no latch is inferred.
    y = a + b;
    case (alu_ctrl_e'(alu_ctrl))
      ALU_SUB:  y = a - b;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  y = a ^ b;
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = a + b;
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// Iterative execute-stage ALU. Single-cycle ops complete through alu_core;
// shifts run one bit per cycle in a serial shifter. Results are registered
// and presented through a valid/ready handshake.
module alu_exec
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  // Shift-amount width follows the operand width; not meant to be overridden.
  localparam int SHW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [XLEN-1:0] shreg_q;
  logic [SHW-1:0]  cnt_q;
  logic [3:0]      sh_op_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;

  logic [SHW-1:0]  shamt;
  logic            accept;
  logic            accept_shift;
  logic            last_step;
  logic [XLEN-1:0] core_y;
  logic [XLEN-1:0] shifted;

  assign shamt        = op_b[SHW-1:0];
  assign accept       = (state_q == ST_IDLE) && in_valid;
  assign accept_shift = accept && is_shift_op(alu_ctrl);
  assign last_step    = (cnt_q == SHW'(1));

  alu_core #(.XLEN(XLEN)) u_core (
    .alu_ctrl (alu_ctrl),
    .a        (op_a),
    .b        (op_b),
    .y        (core_y)
  );

  // One-bit step of the serial shifter for the captured shift kind.
  always_comb begin
    shifted = {shreg_q[XLEN-2:0], 1'b0};
    case (sh_op_q)
      ALU_CODE_SRL: shifted = {1'b0, shreg_q[XLEN-1:1]};
      ALU_CODE_SRA: shifted = {shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
      default:      shifted = {shreg_q[XLEN-2:0], 1'b0};
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and handshake outputs decoded from state only.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (is_shift_op(alu_ctrl) && (shamt != '0)) state_d = ST_SHIFT;
          else                                        state_d = ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (last_step) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Serial shifter, step counter and captured shift kind.
  always_ff @(posedge clk) begin
    // NOTE: the shift register is a plain datapath register, not a memory array, so it is reset with everything else.
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      sh_op_q <= ALU_CODE_SLL;
    end else if (accept_shift) begin
      shreg_q <= op_a;
      cnt_q   <= shamt;
      sh_op_q <= alu_ctrl;
    end else if (state_q == ST_SHIFT) begin
      shreg_q <= shifted;
      cnt_q   <= cnt_q - SHW'(1);
    end
  end

  // Result and zero-flag registers; only written when an operation completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b0;
    end else if (accept && !is_shift_op(alu_ctrl)) begin
      result_q <= core_y;
      zero_q   <= (core_y == '0);
    end else if (accept_shift && (shamt == '0)) begin
      result_q <= op_a;
      zero_q   <= (op_a == '0);
    end else if ((state_q == ST_SHIFT) && last_step) begin
      result_q <= shifted;
      zero_q   <= (shifted == '0);
    end
  end

  assign result = result_q;
  assign zero   = zero_q;

endmodule
